unit3_issue_queue: RTL and testbench



---
 rtl/unit3_issue_queue_pkg.sv | 21 ++
 rtl/unit3_issue_queue_iq_operand.sv | 35 +++
 rtl/unit3_issue_queue.sv | 188 ++++++++++++++++++
 tb/tb_unit3_issue_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unit3_issue_queue_pkg.sv
// Shared encodings and types for the unit3 issue queue.
package unit3_issue_queue_pkg;

    localparam logic [5:0] OPE_NOP  = 6'b000000;
    localparam logic [5:0] OPE_ADDI = 6'b001000;
    localparam logic [5:0] OPE_ADD  = 6'b001100;
    localparam logic [5:0] OPE_SUB  = 6'b010100;
    localparam logic [5:0] OPE_LUI  = 6'b110000;

    localparam logic [3:0] CTRL_NONE = 4'b0000;
    localparam logic [3:0] CTRL_FADD = 4'b0011;

    localparam int unsigned TAG_ZERO = 0;

    typedef struct packed {
        logic [5:0]  ope;
        logic [3:0]  ctrl;
        logic [15:0] imm;
    } op_t;

endpackage

// File: rtl/unit3_issue_queue_iq_operand.sv
// One operand slot: compares its producer tag against both result buses and captures the value.
module unit3_issue_queue_iq_operand
    import unit3_issue_queue_pkg::*;
#(
    parameter int unsigned TAG_W = 6
) (
    input  logic [TAG_W-1:0] tag,
    input  logic             rdy,
    input  logic [31:0]      val,
    input  logic [TAG_W-1:0] alu_addr,
    input  logic [31:0]      alu_dd_val,
    input  logic [TAG_W-1:0] fpu_addr,
    input  logic [31:0]      fpu_dd_val,
    output logic             woke_rdy,
    output logic [31:0]      woke_val
);

    always_comb begin
        woke_rdy = rdy;
        woke_val = val;
        if (!rdy) begin
            // The zero register is always available with the value supplied at decode.
            if (tag == TAG_W'(TAG_ZERO)) begin
                woke_rdy = 1'b1;
            end else if (alu_addr != TAG_W'(TAG_ZERO) && alu_addr == tag) begin
                woke_rdy = 1'b1;
                woke_val = alu_dd_val;
            end else if (fpu_addr != TAG_W'(TAG_ZERO) && fpu_addr == tag) begin
                woke_rdy = 1'b1;
                woke_val = fpu_dd_val;
            end
        end
    end

endmodule

// File: rtl/unit3_issue_queue.sv
// Collapsing reservation station in front of unit3: captures late operands from the ALU/FPU
// result buses and issues the oldest fully-ready op each cycle.
module unit3_issue_queue
    import unit3_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_ope,
    input  logic [3:0]       in_ctrl,
    input  logic [TAG_W-1:0] in_dd,
    input  logic [15:0]      in_imm,
    input  logic [31:0]      in_ds_val,
    input  logic [31:0]      in_dt_val,
    input  logic [TAG_W-1:0] in_ds_tag,
    input  logic [TAG_W-1:0] in_dt_tag,
    input  logic             in_ds_rdy,
    input  logic             in_dt_rdy,
    input  logic [TAG_W-1:0] alu_addr,
    input  logic [TAG_W-1:0] fpu_addr,
    input  logic [31:0]      alu_dd_val,
    input  logic [31:0]      fpu_dd_val,
    input  logic [6:0]       unit_busy,
    output logic [5:0]       iss_ope,
    output logic [3:0]       iss_ctrl,
    output logic [TAG_W-1:0] iss_dd,
    output logic [15:0]      iss_imm,
    output logic [31:0]      iss_ds_val,
    output logic [31:0]      iss_dt_val,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        op_t              op;
        logic [TAG_W-1:0] dd;
        logic [31:0]      ds_val;
        logic [TAG_W-1:0] ds_tag;
        logic             ds_rdy;
        logic [31:0]      dt_val;
        logic [TAG_W-1:0] dt_tag;
        logic             dt_rdy;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woke  [DEPTH+1];
    entry_t           ins_ent;
    logic [CNT_W-1:0] count_q, count_d, ins_idx;
    logic [IDX_W-1:0] sel;
    logic             any_rdy, issue, accept;
    logic             ds_w_rdy [DEPTH];
    logic             dt_w_rdy [DEPTH];
    logic [31:0]      ds_w_val [DEPTH];
    logic [31:0]      dt_w_val [DEPTH];
    logic             ins_ds_rdy, ins_dt_rdy;
    logic [31:0]      ins_ds_val, ins_dt_val;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        unit3_issue_queue_iq_operand #(.TAG_W(TAG_W)) u_ds (
            .tag(ent_q[i].ds_tag), .rdy(ent_q[i].ds_rdy), .val(ent_q[i].ds_val),
            .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
            .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
            .woke_rdy(ds_w_rdy[i]), .woke_val(ds_w_val[i])
        );
        unit3_issue_queue_iq_operand #(.TAG_W(TAG_W)) u_dt (
            .tag(ent_q[i].dt_tag), .rdy(ent_q[i].dt_rdy), .val(ent_q[i].dt_val),
            .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
            .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
            .woke_rdy(dt_w_rdy[i]), .woke_val(dt_w_val[i])
        );
    end

    // Insert bypass so a broadcast in the insert cycle is not missed.
    unit3_issue_queue_iq_operand #(.TAG_W(TAG_W)) u_ins_ds (
        .tag(in_ds_tag), .rdy(in_ds_rdy), .val(in_ds_val),
        .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
        .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
        .woke_rdy(ins_ds_rdy), .woke_val(ins_ds_val)
    );
    unit3_issue_queue_iq_operand #(.TAG_W(TAG_W)) u_ins_dt (
        .tag(in_dt_tag), .rdy(in_dt_rdy), .val(in_dt_val),
        .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
        .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
        .woke_rdy(ins_dt_rdy), .woke_val(ins_dt_val)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]        = ent_q[i];
            woke[i].ds_rdy = ds_w_rdy[i];
            woke[i].ds_val = ds_w_val[i];
            woke[i].dt_rdy = dt_w_rdy[i];
            woke[i].dt_val = dt_w_val[i];
        end
        // Empty slot shifted into the top entry on issue.
        woke[DEPTH] = '0;
    end

    always_comb begin
        ins_ent         = '0;
        ins_ent.valid   = 1'b1;
        ins_ent.op.ope  = in_ope;
        ins_ent.op.ctrl = in_ctrl;
        ins_ent.op.imm  = in_imm;
        ins_ent.dd      = in_dd;
        ins_ent.ds_tag  = in_ds_tag;
        ins_ent.ds_rdy  = ins_ds_rdy;
        ins_ent.ds_val  = ins_ds_val;
        ins_ent.dt_tag  = in_dt_tag;
        ins_ent.dt_rdy  = ins_dt_rdy;
        ins_ent.dt_val  = ins_dt_val;
    end

    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].ds_rdy && ent_q[i].dt_rdy) begin
                any_rdy = 1'b1;
                sel     = IDX_W'(i);
            end
        end
    end

    assign in_ready = count_q < CNT_W'(DEPTH);
    assign issue    = any_rdy && (unit_busy == '0) && !flush;
    assign accept   = in_valid && in_ready && !flush;
    assign ins_idx  = count_q - CNT_W'(issue);
    assign count_d  = flush ? '0 : count_q + CNT_W'(accept) - CNT_W'(issue);
    assign count    = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && IDX_W'(i) >= sel) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (accept && CNT_W'(i) == ins_idx) begin
                ent_d[i] = ins_ent;
            end
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q    <= '0;
            iss_ope    <= OPE_NOP;
            iss_ctrl   <= CTRL_NONE;
            iss_dd     <= '0;
            iss_imm    <= '0;
            iss_ds_val <= '0;
            iss_dt_val <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            if (issue) begin
                iss_ope    <= ent_q[sel].op.ope;
                iss_ctrl   <= ent_q[sel].op.ctrl;
                iss_dd     <= ent_q[sel].dd;
                iss_imm    <= ent_q[sel].op.imm;
                iss_ds_val <= ent_q[sel].ds_val;
                iss_dt_val <= ent_q[sel].dt_val;
            end else begin
                iss_ope  <= OPE_NOP;
                iss_ctrl <= CTRL_NONE;
            end
        end
    end

endmodule

// File: tb/tb_unit3_issue_queue.sv
// Self-checking bench for unit3_issue_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_unit3_issue_queue;
    import unit3_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush, in_valid, in_ready;
    logic [5:0]       in_ope;
    logic [3:0]       in_ctrl;
    logic [TAG_W-1:0] in_dd, in_ds_tag, in_dt_tag, alu_addr, fpu_addr;
    logic [15:0]      in_imm;
    logic [31:0]      in_ds_val, in_dt_val, alu_dd_val, fpu_dd_val;
    logic             in_ds_rdy, in_dt_rdy;
    logic [6:0]       unit_busy;
    logic [5:0]       iss_ope;
    logic [3:0]       iss_ctrl;
    logic [TAG_W-1:0] iss_dd;
    logic [15:0]      iss_imm;
    logic [31:0]      iss_ds_val, iss_dt_val;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int failures = 0;

    unit3_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ope(in_ope), .in_ctrl(in_ctrl), .in_dd(in_dd), .in_imm(in_imm),
        .in_ds_val(in_ds_val), .in_dt_val(in_dt_val), .in_ds_tag(in_ds_tag),
        .in_dt_tag(in_dt_tag), .in_ds_rdy(in_ds_rdy), .in_dt_rdy(in_dt_rdy),
        .alu_addr(alu_addr), .fpu_addr(fpu_addr), .alu_dd_val(alu_dd_val),
        .fpu_dd_val(fpu_dd_val), .unit_busy(unit_busy), .iss_ope(iss_ope),
        .iss_ctrl(iss_ctrl), .iss_dd(iss_dd), .iss_imm(iss_imm), .iss_ds_val(iss_ds_val),
        .iss_dt_val(iss_dt_val), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: an age-ordered list of waiting ops plus the expected issue register.
    typedef struct {
        logic [5:0]       ope;
        logic [3:0]       ctrl;
        logic [TAG_W-1:0] dd;
        logic [15:0]      imm;
        logic [31:0]      dsv;
        logic [TAG_W-1:0] dst;
        bit               dsr;
        logic [31:0]      dtv;
        logic [TAG_W-1:0] dtt;
        bit               dtr;
    } m_op_t;

    m_op_t            mq[$];
    logic [5:0]       e_ope;
    logic [3:0]       e_ctrl;
    logic [TAG_W-1:0] e_dd;
    logic [15:0]      e_imm;
    logic [31:0]      e_dsv, e_dtv;

    function automatic void model_reset();
        mq.delete();
        e_ope = '0; e_ctrl = '0; e_dd = '0; e_imm = '0; e_dsv = '0; e_dtv = '0;
    endfunction

    function automatic void wake(input bit r_in, input logic [TAG_W-1:0] t,
                                 input logic [31:0] v_in, output bit r, output logic [31:0] v);
        r = r_in;
        v = v_in;
        if (!r_in) begin
            if (t == '0) r = 1'b1;
            else if (alu_addr == t) begin r = 1'b1; v = alu_dd_val; end
            else if (fpu_addr == t) begin r = 1'b1; v = fpu_dd_val; end
        end
    endfunction

    function automatic void model_step();
        int sel;
        bit acc;
        bit r;
        logic [31:0] v;
        m_op_t e;
        sel = -1;
        acc = in_valid && (mq.size() < DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            e_ope = '0;
            e_ctrl = '0;
            return;
        end
        if (unit_busy == '0) begin
            for (int i = 0; i < mq.size(); i++)
                if (sel < 0 && mq[i].dsr && mq[i].dtr) sel = i;
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            wake(e.dsr, e.dst, e.dsv, r, v); e.dsr = r; e.dsv = v;
            wake(e.dtr, e.dtt, e.dtv, r, v); e.dtr = r; e.dtv = v;
            mq[i] = e;
        end
        if (sel >= 0) begin
            e = mq[sel];
            e_ope = e.ope; e_ctrl = e.ctrl; e_dd = e.dd; e_imm = e.imm;
            e_dsv = e.dsv; e_dtv = e.dtv;
            mq.delete(sel);
        end else begin
            e_ope = '0;
            e_ctrl = '0;
        end
        if (acc) begin
            e.ope = in_ope; e.ctrl = in_ctrl; e.dd = in_dd; e.imm = in_imm;
            e.dst = in_ds_tag; e.dtt = in_dt_tag;
            wake(in_ds_rdy, in_ds_tag, in_ds_val, r, v); e.dsr = r; e.dsv = v;
            wake(in_dt_rdy, in_dt_tag, in_dt_val, r, v); e.dtr = r; e.dtv = v;
            mq.push_back(e);
        end
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_ope = '0; in_ctrl = '0; in_dd = '0; in_imm = '0;
        in_ds_val = '0; in_dt_val = '0; in_ds_tag = '0; in_dt_tag = '0;
        in_ds_rdy = 0; in_dt_rdy = 0; alu_addr = '0; fpu_addr = '0;
        alu_dd_val = '0; fpu_dd_val = '0; unit_busy = '0;
    endtask

    task automatic put_op(input logic [5:0] ope, input logic [TAG_W-1:0] dd,
                          input logic [31:0] dsv, input logic [TAG_W-1:0] dst, input bit dsr,
                          input logic [31:0] dtv, input logic [TAG_W-1:0] dtt, input bit dtr);
        in_valid = 1; in_ope = ope; in_ctrl = '0; in_imm = '0; in_dd = dd;
        in_ds_val = dsv; in_ds_tag = dst; in_ds_rdy = dsr;
        in_dt_val = dtv; in_dt_tag = dtt; in_dt_rdy = dtr;
    endtask

    task automatic test_reset();
        idle();
        rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if ({iss_ope, iss_ctrl, iss_dd, iss_imm, iss_ds_val, iss_dt_val} !== '0) begin
            failures++;
            $display("FAIL reset_iss got ope=%h ds=%h dt=%h want all zero", iss_ope, iss_ds_val, iss_dt_val);
        end
        rstn = 1;
        model_reset();
    endtask

    task automatic test_basic();
        put_op(OPE_ADD, 6'd3, 32'd5, '0, 1, 32'd7, '0, 1);
        cycle();
        idle();
        checks++;
        if (count !== 3'd1 || iss_ope !== 6'd0) begin
            failures++; $display("FAIL basic_enq got count=%0d ope=%h want 1/00", count, iss_ope);
        end
        cycle();
        checks++;
        if ({iss_ope, iss_ds_val, iss_dt_val, iss_dd} !== {OPE_ADD, 32'd5, 32'd7, 6'd3}) begin
            failures++;
            $display("FAIL basic_issue got ope=%h ds=%0d dt=%0d dd=%0d want 0c/5/7/3", iss_ope, iss_ds_val, iss_dt_val, iss_dd);
        end
        cycle();
        checks++;
        if (iss_ope !== OPE_NOP || count !== '0) begin
            failures++; $display("FAIL basic_nop got ope=%h count=%0d want 00/0", iss_ope, count);
        end
    endtask

    task automatic test_wakeup_order();
        put_op(OPE_ADDI, 6'd4, 32'd1, '0, 1, 32'd0, 6'd9, 0);
        cycle();
        put_op(OPE_ADD, 6'd5, 32'd2, '0, 1, 32'd3, '0, 1);
        cycle();
        idle();
        checks++;
        if (iss_ope !== OPE_NOP || count !== 3'd2) begin
            failures++; $display("FAIL wake_wait got ope=%h count=%0d want 00/2", iss_ope, count);
        end
        alu_addr = 6'd9;
        alu_dd_val = 32'h1234;
        cycle();
        idle();
        checks++;
        if (iss_ope !== OPE_ADD || iss_dd !== 6'd5) begin
            failures++; $display("FAIL wake_young_first got ope=%h dd=%0d want 0c/5", iss_ope, iss_dd);
        end
        cycle();
        checks++;
        if ({iss_ope, iss_dd, iss_dt_val, iss_ds_val} !== {OPE_ADDI, 6'd4, 32'h1234, 32'd1}) begin
            failures++;
            $display("FAIL wake_capture got ope=%h dd=%0d dt=%h want 08/4/1234", iss_ope, iss_dd, iss_dt_val);
        end
        cycle();
    endtask

    task automatic test_busy_fill();
        for (int k = 0; k < DEPTH; k++) begin
            put_op(OPE_ADD, 6'(10 + k), 32'(k), '0, 1, 32'(k + 100), '0, 1);
            unit_busy = 7'h01;
            cycle();
            checks++;
            if (iss_ope !== OPE_NOP || count !== CNT_W'(k + 1)) begin
                failures++;
                $display("FAIL busy_fill k=%0d got ope=%h count=%0d want 00/%0d", k, iss_ope, count, k + 1);
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_full_ready got=%b want=0", in_ready); end
        put_op(OPE_SUB, 6'd30, 32'd0, '0, 1, 32'd0, '0, 1);
        cycle();
        checks++;
        if (count !== 3'd4 || iss_ope !== OPE_NOP) begin
            failures++; $display("FAIL busy_block got count=%0d ope=%h want 4/00", count, iss_ope);
        end
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            cycle();
            checks++;
            if (iss_dd !== 6'(10 + k) || iss_ds_val !== 32'(k) || count !== CNT_W'(3 - k)) begin
                failures++;
                $display("FAIL busy_drain k=%0d got dd=%0d ds=%0d count=%0d want %0d/%0d/%0d", k, iss_dd, iss_ds_val, count, 10 + k, k, 3 - k);
            end
        end
        cycle();
    endtask

    task automatic test_insert_bypass();
        put_op(OPE_SUB, 6'd6, 32'h0, 6'd12, 0, 32'd1, '0, 1);
        fpu_addr = 6'd12;
        fpu_dd_val = 32'hDEAD;
        cycle();
        idle();
        cycle();
        checks++;
        if ({iss_ope, iss_ds_val, iss_dd} !== {OPE_SUB, 32'hDEAD, 6'd6} || count !== '0) begin
            failures++;
            $display("FAIL bypass got ope=%h ds=%h dd=%0d count=%0d want 14/dead/6/0", iss_ope, iss_ds_val, iss_dd, count);
        end
        cycle();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            put_op(OPE_ADD, 6'(20 + k), 32'd1, '0, 1, 32'd2, '0, 1);
            unit_busy = 7'h10;
            cycle();
        end
        checks++;
        if (count !== 3'd3) begin failures++; $display("FAIL flush_pre got count=%0d want 3", count); end
        put_op(OPE_LUI, 6'd25, 32'd1, '0, 1, 32'd2, '0, 1);
        unit_busy = '0;
        flush = 1;
        cycle();
        idle();
        checks++;
        if (count !== '0 || iss_ope !== OPE_NOP || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush got count=%0d ope=%h ready=%b want 0/00/1", count, iss_ope, in_ready);
        end
        cycle();
        checks++;
        if (count !== '0 || iss_ope !== OPE_NOP) begin
            failures++; $display("FAIL flush_no_insert got count=%0d ope=%h want 0/00", count, iss_ope);
        end
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            flush      = ($urandom_range(0, 31) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_ope     = 6'($urandom);
            in_ctrl    = 4'($urandom);
            in_dd      = 6'($urandom);
            in_imm     = 16'($urandom);
            in_ds_val  = $urandom;
            in_dt_val  = $urandom;
            in_ds_tag  = 6'($urandom_range(0, 7));
            in_dt_tag  = 6'($urandom_range(0, 7));
            in_ds_rdy  = $urandom_range(0, 1) == 1;
            in_dt_rdy  = $urandom_range(0, 1) == 1;
            alu_addr   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 7)) : '0;
            fpu_addr   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 7)) : '0;
            alu_dd_val = $urandom;
            fpu_dd_val = $urandom;
            unit_busy  = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : '0;
            cycle();
            checks++;
            if (count !== CNT_W'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
                failures++;
                $display("FAIL rand_count c=%0d got count=%0d ready=%b want %0d", c, count, in_ready, mq.size());
            end
            checks++;
            if ({iss_ope, iss_ctrl, iss_dd, iss_imm, iss_ds_val, iss_dt_val}
                    !== {e_ope, e_ctrl, e_dd, e_imm, e_dsv, e_dtv}) begin
                failures++;
                $display("FAIL rand_issue c=%0d got %h/%h/%h/%h/%h/%h want %h/%h/%h/%h/%h/%h", c,
                         iss_ope, iss_ctrl, iss_dd, iss_imm, iss_ds_val, iss_dt_val,
                         e_ope, e_ctrl, e_dd, e_imm, e_dsv, e_dtv);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        #2;
        rstn = 0;
        #1;
        checks++;
        if (count !== '0 || in_ready !== 1'b1 ||
            {iss_ope, iss_ctrl, iss_dd, iss_imm, iss_ds_val, iss_dt_val} !== '0) begin
            failures++;
            $display("FAIL reset_mid got count=%0d ope=%h ds=%h want 0/00/0", count, iss_ope, iss_ds_val);
        end
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rstn = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup_order();
        test_busy_fill();
        test_insert_bypass();
        test_flush();
        test_random(600);
        put_op(OPE_ADD, 6'd1, 32'd1, 6'd7, 0, 32'd2, 6'd7, 0);
        unit_busy = 7'h40;
        cycle();
        cycle();
        idle();
        test_reset_mid();
        test_random(200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
